// File: rtl/jsilicon_pkg.sv
// jsilicon_pkg: opcodes, FSM states and instruction field offsets shared by the core
package jsilicon_pkg;
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_MUL  = 4'h7;
   localparam logic [3:0] OP_OUT  = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
   localparam logic [3:0] OP_JZ   = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;
   localparam int OP_LSB = 12;
   localparam int RD_LSB = 8;
   localparam int RS_LSB = 4;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_OUT, S_HALT} state_t;
endpackage

// File: rtl/jsilicon_regfile.sv
// jsilicon_regfile: NREGS x DATA_W register file, two async read ports, one sync write port
module jsilicon_regfile #(
   parameter int DATA_W = 8,
   parameter int NREGS = 4,
   localparam int RSEL_W = $clog2(NREGS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [RSEL_W-1:0] wr_sel,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [RSEL_W-1:0] sel_a,
   input  logic [RSEL_W-1:0] sel_b,
   output logic [DATA_W-1:0] data_a,
   output logic [DATA_W-1:0] data_b
);
   logic [DATA_W-1:0] regs [NREGS];
   // clear every register on reset, otherwise write the selected one
   always_ff @(posedge clock)
      if (reset) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      else if (wr_en) regs[wr_sel] <= wr_data;
   assign data_a = regs[sel_a];
   assign data_b = regs[sel_b];
endmodule

// File: rtl/jsilicon_core.sv
// jsilicon_core: multi-cycle CPU core with program RAM, register file and valid/ready result port
module jsilicon_core import jsilicon_pkg::*; #(
   parameter int DATA_W = 8,
   parameter int NREGS = 4,
   parameter int PROG_DEPTH = 16,
   localparam int RSEL_W = $clog2(NREGS),
   localparam int ADDR_W = $clog2(PROG_DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ena,
   input  logic              run,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [15:0]       prog_wdata,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [DATA_W-1:0] tx_data,
   output logic [ADDR_W-1:0] pc_out,
   output logic              busy,
   output logic              halted,
   output logic              zero_flag
);
   state_t state;
   logic [15:0] mem [PROG_DEPTH];
   logic [ADDR_W-1:0] pc;
   logic [3:0] op;
   logic [RSEL_W-1:0] rd;
   logic [7:0] imm;
   logic [DATA_W-1:0] a, b, alu, ra_data, rb_data;
   logic parked, alu_op, jump, wr_en;
   assign parked = state == S_IDLE || state == S_HALT;
   assign alu_op = op >= OP_ADD && op <= OP_MUL;
   assign jump = op == OP_JMP || (op == OP_JZ && a == '0);
   assign wr_en = ena && state == S_EXEC && (op == OP_LDI || alu_op);
   // operands a/b are latched in decode, so JZ sees rd before this instruction
   always_comb
      alu = op == OP_ADD ? a + b :
            op == OP_SUB ? a - b :
            op == OP_AND ? a & b :
            op == OP_OR  ? a | b :
            op == OP_XOR ? a ^ b : a * b;
   jsilicon_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regs (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(rd),
      .wr_data(op == OP_LDI ? DATA_W'(imm) : alu),
      .sel_a(rd), .sel_b(imm[RS_LSB +: RSEL_W]), .data_a(ra_data), .data_b(rb_data)
   );
   // program RAM is writable only while the core is parked and enabled
   always_ff @(posedge clock)
      if (reset) for (int i = 0; i < PROG_DEPTH; i++) mem[i] <= '0;
      else if (ena && prog_we && parked) mem[prog_addr] <= prog_wdata;
   // control FSM: fetch, decode, execute, optional output handshake
   always_ff @(posedge clock)
      if (reset) begin
         state <= S_IDLE;
         pc <= '0;
         op <= OP_NOP;
         rd <= '0;
         imm <= '0;
         a <= '0;
         b <= '0;
         tx_valid <= 1'b0;
         tx_data <= '0;
         zero_flag <= 1'b0;
      end else if (ena) begin
         case (state)
            S_IDLE, S_HALT: if (run) begin
               state <= S_FETCH;
               pc <= '0;
            end
            S_FETCH: begin
               op <= mem[pc][OP_LSB +: 4];
               rd <= mem[pc][RD_LSB +: RSEL_W];
               imm <= mem[pc][7:0];
               state <= S_DECODE;
            end
            S_DECODE: begin
               a <= ra_data;
               b <= rb_data;
               state <= S_EXEC;
            end
            S_EXEC: begin
               pc <= jump ? imm[ADDR_W-1:0] : pc + ADDR_W'(1);
               if (alu_op) zero_flag <= alu == '0;
               if (op == OP_OUT) begin
                  tx_valid <= 1'b1;
                  tx_data <= b;
                  state <= S_OUT;
               end else state <= op == OP_HALT ? S_HALT : S_FETCH;
            end
            S_OUT: if (tx_ready) begin
               tx_valid <= 1'b0;
               state <= S_FETCH;
            end
            default: state <= S_IDLE;
         endcase
      end
   assign pc_out = pc;
   assign busy = !parked;
   assign halted = state == S_HALT;
endmodule

// File: tb/tb_jsilicon_core.sv
// tb_jsilicon_core: directed programs checked against an instruction-level model of the ISA
module tb_jsilicon_core;
   logic clock = 0, reset = 1, ena = 1, run = 0, prog_we = 0, tx_ready = 1;
   logic [3:0] prog_addr = 0;
   logic [15:0] prog_wdata = 0;
   logic tx_valid, busy, halted, zero_flag;
   logic [7:0] tx_data;
   logic [3:0] pc_out;

   jsilicon_core dut (
      .clock(clock), .reset(reset), .ena(ena), .run(run), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_wdata(prog_wdata), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_data(tx_data), .pc_out(pc_out), .busy(busy),
      .halted(halted), .zero_flag(zero_flag)
   );

   always #5 clock = ~clock;

   int checks = 0, failures = 0, hs = 0, hs0 = 0;
   logic [7:0] exp_q [$];
   logic [15:0] img [16];
   logic [15:0] pg [$];
   int mr [4];
   int mpc, mz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ri(input int op, input int rd, input int imm);
      logic [15:0] w;
      w = {op[3:0], rd[3:0], imm[7:0]};
      return w;
   endfunction

   function automatic logic [15:0] rr(input int op, input int rd, input int rs);
      return ri(op, rd, rs * 16);
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // instruction-level reference: runs the image from pc 0, queues every OUT value
   task automatic model_run(output int steps, output int nout);
      int pc, op, rd, rs, imm, r;
      bit stop;
      pc = 0; steps = 0; nout = 0; stop = 0;
      while (!stop && steps < 1000) begin
         op = int'(img[pc][15:12]);
         rd = int'(img[pc][9:8]);
         rs = int'(img[pc][5:4]);
         imm = int'(img[pc][7:0]);
         steps++;
         pc = (pc + 1) % 16;
         if (op >= 2 && op <= 7) begin
            case (op)
               2: r = mr[rd] + mr[rs];
               3: r = mr[rd] - mr[rs];
               4: r = mr[rd] & mr[rs];
               5: r = mr[rd] | mr[rs];
               6: r = mr[rd] ^ mr[rs];
               default: r = mr[rd] * mr[rs];
            endcase
            mr[rd] = r & 'hFF;
            mz = (mr[rd] == 0) ? 1 : 0;
         end else if (op == 1) mr[rd] = imm;
         else if (op == 8) begin
            exp_q.push_back(mr[rs][7:0]);
            nout++;
         end else if (op == 9 || (op == 10 && mr[rd] == 0)) pc = imm % 16;
         else if (op == 15) stop = 1;
      end
      mpc = pc;
   endtask

   task automatic do_reset();
      reset = 1;
      exp_q.delete();
      tick(2);
      reset = 0;
      for (int i = 0; i < 16; i++) img[i] = 0;
      for (int i = 0; i < 4; i++) mr[i] = 0;
      mz = 0;
   endtask

   task automatic load();
      for (int i = 0; i < pg.size(); i++) begin
         prog_we = 1;
         prog_addr = i[3:0];
         prog_wdata = pg[i];
         img[i] = pg[i];
         tick();
      end
      prog_we = 0;
   endtask

   task automatic start(output int steps, output int nout);
      model_run(steps, nout);
      hs0 = hs;
      run = 1;
      tick();
      run = 0;
   endtask

   task automatic wait_halt(input string name, input bit timed, input int steps, input int nout, output int cyc);
      cyc = 0;
      while (!halted && cyc < 400) begin
         tick();
         cyc++;
      end
      chk({name, "_halted"}, halted, 1);
      if (timed) chk({name, "_cycles"}, cyc, 3 * steps + nout);
      chk({name, "_pc"}, pc_out, mpc);
      chk({name, "_zero"}, zero_flag, mz);
      chk({name, "_outs"}, hs - hs0, nout);
      chk({name, "_drained"}, exp_q.size(), 0);
   endtask

   // per-cycle monitor: handshakes against the model queue, hold rules while stalled
   logic [7:0] prev_data;
   logic [3:0] prev_pc;
   bit prev_stall = 0;
   always @(negedge clock) begin
      if (reset) prev_stall = 0;
      else begin
         if (prev_stall) begin
            chk("hold_valid", tx_valid, 1);
            chk("hold_data", tx_data, prev_data);
            chk("hold_pc", pc_out, prev_pc);
         end
         chk("busy_halt_excl", busy & halted, 0);
         if (tx_valid && tx_ready && ena) begin
            hs++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
            end else chk("tx_data", tx_data, exp_q.pop_front());
         end
         prev_stall = tx_valid && !(tx_ready && ena);
         prev_data = tx_data;
         prev_pc = pc_out;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int steps, nout, cyc, p;
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_valid", tx_valid, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_zero", zero_flag, 0);
      chk("rst_halted", halted, 0);

      // T1: reset while an output is pending, then read all registers back
      pg = '{ri(1, 0, 7), ri(1, 1, 9), rr(8, 0, 0), ri(15, 0, 0)};
      load();
      tx_ready = 0;
      start(steps, nout);
      for (int i = 0; i < 30 && !tx_valid; i++) tick();
      chk("t1_pending", tx_valid, 1);
      do_reset();
      chk("t1_busy", busy, 0);
      chk("t1_pc", pc_out, 0);
      chk("t1_valid", tx_valid, 0);
      chk("t1_data", tx_data, 0);
      tx_ready = 1;
      pg = '{rr(8, 0, 0), rr(8, 0, 1), rr(8, 0, 2), rr(8, 0, 3), ri(15, 0, 0)};
      load();
      start(steps, nout);
      chk("t1_model_nout", nout, 4);
      wait_halt("t1", 1, steps, nout, cyc);

      // T2: 5 + 3 emitted once
      pg = '{ri(1, 0, 5), ri(1, 1, 3), rr(2, 0, 1), rr(8, 0, 0), ri(15, 0, 0)};
      load();
      start(steps, nout);
      chk("t2_model_val", exp_q[0], 8);
      chk("t2_model_nout", nout, 1);
      wait_halt("t2", 1, steps, nout, cyc);
      chk("t2_cycles_lit", cyc, 16);
      chk("t2_zero_lit", zero_flag, 0);

      // T3: 8-bit wrap on ADD and MUL, then the logic ops
      pg = '{ri(1, 0, 'hFF), ri(1, 1, 1), rr(2, 0, 1), rr(8, 0, 0), ri(15, 0, 0)};
      load();
      start(steps, nout);
      chk("t3a_model_val", exp_q[0], 0);
      wait_halt("t3a", 1, steps, nout, cyc);
      chk("t3a_zero_lit", zero_flag, 1);
      pg = '{ri(1, 2, 'h10), ri(1, 3, 'h10), rr(7, 2, 3), rr(8, 0, 2), ri(15, 0, 0)};
      load();
      start(steps, nout);
      chk("t3b_model_val", exp_q[0], 0);
      wait_halt("t3b", 1, steps, nout, cyc);
      pg = '{ri(1, 0, 'hC5), ri(1, 1, 'h0F), rr(4, 0, 1), rr(8, 0, 0), rr(5, 0, 1),
             rr(6, 0, 1), rr(8, 0, 0), rr(3, 0, 1), rr(8, 0, 0), ri(15, 0, 0)};
      load();
      start(steps, nout);
      chk("t3c_model_v0", exp_q[0], 'h05);
      chk("t3c_model_v1", exp_q[1], 'h00);
      chk("t3c_model_v2", exp_q[2], 'hF1);
      wait_halt("t3c", 1, steps, nout, cyc);
      chk("t3c_zero_lit", zero_flag, 0);

      // T4: back-pressure on the output port, with a disabled cycle pair
      pg = '{ri(1, 1, 'h5A), rr(8, 0, 1), ri(1, 0, 1), ri(15, 0, 0)};
      load();
      tx_ready = 0;
      start(steps, nout);
      for (int i = 0; i < 20 && !tx_valid; i++) tick();
      chk("t4_valid", tx_valid, 1);
      repeat (5) begin
         tick();
         chk("t4_stall_data", tx_data, 'h5A);
         chk("t4_stall_pc", pc_out, 2);
         chk("t4_stall_busy", busy, 1);
      end
      ena = 0;
      tx_ready = 1;
      tick(2);
      chk("t4_ena0_valid", tx_valid, 1);
      chk("t4_ena0_outs", hs - hs0, 0);
      ena = 1;
      wait_halt("t4", 0, steps, nout, cyc);

      // T5: countdown loop runs exactly twice
      pg = '{ri(1, 2, 2), ri(1, 3, 1), rr(3, 2, 3), ri(10, 2, 5), ri(9, 0, 2), rr(8, 0, 2), ri(15, 0, 0)};
      load();
      start(steps, nout);
      chk("t5_model_steps", steps, 9);
      wait_halt("t5", 1, steps, nout, cyc);
      chk("t5_cycles_lit", cyc, 28);
      chk("t5_pc_lit", pc_out, 7);

      // T6: no HALT, pc wraps; writes while busy are dropped; ena=0 freezes
      do_reset();
      pg = '{ri(1, 0, 1)};
      load();
      start(steps, nout);
      for (int i = 0; i < 100 && pc_out != 15; i++) tick();
      chk("t6_reach15", pc_out, 15);
      for (int i = 0; i < 6 && pc_out != 0; i++) tick();
      chk("t6_wrap", pc_out, 0);
      prog_we = 1;
      prog_addr = 3;
      prog_wdata = ri(15, 0, 0);
      tick();
      prog_we = 0;
      for (int i = 0; i < 30 && pc_out != 6; i++) tick();
      chk("t6_pc6", pc_out, 6);
      chk("t6_not_halted", halted, 0);
      chk("t6_busy", busy, 1);
      ena = 0;
      p = int'(pc_out);
      repeat (4) begin
         tick();
         chk("t6_freeze", pc_out, p);
      end
      ena = 1;
      tick(4);
      chk("t6_resume", pc_out == p[3:0], 0);
      do_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
